// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
//
// Two-port arbiter and access sequencer for the single-port data-memory block
// RAM. Port C (CPU memory stage) and port D (debug/bridge) compete for the RAM.
// Requests are granted one at a time, round-robin on ties. Loads read the RAM
// (1-cycle synchronous read latency). Word stores write directly. Byte and
// halfword stores run as a read-modify-write on the single clock: the word is
// read, the selected lane is replaced, and the full word is written back.
//
// Handshake: a requester raises x_req with x_wr/x_size/x_addr/x_wdata stable
// and holds them until x_ack. x_ack is a single-cycle completion pulse. x_rdata
// carries the raw RAM word only while x_ack is high on a load, otherwise 0. The
// requester may drop or change x_req in the cycle after x_ack. The FSM is back
// in IDLE then, so one port may issue back-to-back requests.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   c_req      CPU request
//   c_wr       1 = store, 0 = load
//   c_size     00 byte, 01 half, 10/11 word
//   c_addr     byte address (word index = c_addr[ADDR_W+1:2])
//   c_wdata    right-aligned store data
//   c_ack      completion pulse
//   c_rdata    raw RAM word on load completion, else 0
//   d_*        same set for the debug port
//   ram_we     4'b1111 while writing, else 4'b0000
//   ram_addr   RAM word address (from the holding register)
//   ram_din    RAM write data, 0 when not writing
//   ram_dout   RAM read data, valid the cycle after the address
//   busy       high whenever the FSM is not in IDLE
//   dbg_state  current FSM state, for observation only
// -----------------------------------------------------------------------------
module dm_arbiter #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              c_req,
   input  logic              c_wr,
   input  logic [1:0]        c_size,
   input  logic [31:0]       c_addr,
   input  logic [31:0]       c_wdata,
   output logic              c_ack,
   output logic [31:0]       c_rdata,

   input  logic              d_req,
   input  logic              d_wr,
   input  logic [1:0]        d_size,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_ack,
   output logic [31:0]       d_rdata,

   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,

   output logic              busy,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_LDATA = 3'd2,
      S_WR    = 3'd3,
      S_MERGE = 3'd4
   } state_e;

   localparam logic PORT_C = 1'b0;
   localparam logic PORT_D = 1'b1;

   // ---------------------------------------------------------------------------
   // State and holding registers
   // ---------------------------------------------------------------------------
   state_e              state_q,      state_d;
   logic                last_grant_q, last_grant_d;
   logic                port_q,       port_d;
   logic                rmw_q,        rmw_d;
   logic                half_q,       half_d;
   logic [1:0]          lane_q,       lane_d;
   logic [ADDR_W-1:0]   addr_q,       addr_d;
   logic [31:0]         wdata_q,      wdata_d;

   // Winner of the current arbitration and its request fields
   logic                grant_any;
   logic                grant_port;
   logic                sel_wr;
   logic [1:0]          sel_size;
   logic [31:0]         sel_addr;
   logic [31:0]         sel_wdata;
   logic                sel_word;

   // Read word with the selected byte/half lane replaced
   logic [31:0]         merged;

   // Address bits above the RAM range are intentionally ignored
   logic                unused_addr_hi;
   assign unused_addr_hi = ^{c_addr[31:ADDR_W+2], d_addr[31:ADDR_W+2]};

   // ---------------------------------------------------------------------------
   // Arbitration: a lone request wins; on a tie the port that did not win last
   // time is granted.
   // ---------------------------------------------------------------------------
   always_comb begin
      grant_any = c_req | d_req;
      if (c_req && d_req) begin
         grant_port = ~last_grant_q;
      end else if (d_req) begin
         grant_port = PORT_D;
      end else begin
         grant_port = PORT_C;
      end

      if (grant_port == PORT_D) begin
         sel_wr    = d_wr;
         sel_size  = d_size;
         sel_addr  = d_addr;
         sel_wdata = d_wdata;
      end else begin
         sel_wr    = c_wr;
         sel_size  = c_size;
         sel_addr  = c_addr;
         sel_wdata = c_wdata;
      end

      // Sizes 10 and 11 both mean a full word
      sel_word = sel_size[1];
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      rmw_d        = rmw_q;
      half_d       = half_q;
      lane_d       = lane_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;

      unique case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               last_grant_d = grant_port;
               port_d       = grant_port;
               rmw_d        = sel_wr & ~sel_word;
               half_d       = sel_size[0];
               lane_d       = sel_addr[1:0];
               addr_d       = sel_addr[ADDR_W+1:2];
               wdata_d      = sel_wdata;
               if (sel_wr && sel_word) begin
                  state_d = S_WR;
               end else begin
                  // Loads and sub-word stores both need the word read first
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            state_d = rmw_q ? S_MERGE : S_LDATA;
         end
         S_LDATA: begin
            state_d = S_IDLE;
         end
         S_WR: begin
            state_d = S_IDLE;
         end
         S_MERGE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers. Reset returns to IDLE at once, which drops ram_we and the acks
   // in the same cycle, so an in-flight write or load is abandoned cleanly.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= PORT_D;
         port_q       <= PORT_C;
         rmw_q        <= 1'b0;
         half_q       <= 1'b0;
         lane_q       <= 2'b00;
         addr_q       <= '0;
         wdata_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         rmw_q        <= rmw_d;
         half_q       <= half_d;
         lane_q       <= lane_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Lane merge for sub-word stores. For halves only addr[1] selects the lane.
   // ---------------------------------------------------------------------------
   always_comb begin
      merged = ram_dout;
      if (half_q) begin
         if (lane_q[1]) begin
            merged[31:16] = wdata_q[15:0];
         end else begin
            merged[15:0]  = wdata_q[15:0];
         end
      end else begin
         unique case (lane_q)
            2'b00:   merged[7:0]   = wdata_q[7:0];
            2'b01:   merged[15:8]  = wdata_q[7:0];
            2'b10:   merged[23:16] = wdata_q[7:0];
            default: merged[31:24] = wdata_q[7:0];
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output decode from state and holding registers
   // ---------------------------------------------------------------------------
   logic ack_state;
   logic ldata_state;

   always_comb begin
      ack_state   = (state_q == S_LDATA) || (state_q == S_WR) || (state_q == S_MERGE);
      ldata_state = (state_q == S_LDATA);

      c_ack   = ack_state && (port_q == PORT_C);
      d_ack   = ack_state && (port_q == PORT_D);
      c_rdata = (ldata_state && (port_q == PORT_C)) ? ram_dout : 32'h0;
      d_rdata = (ldata_state && (port_q == PORT_D)) ? ram_dout : 32'h0;

      ram_we  = 4'b0000;
      ram_din = 32'h0;
      if (state_q == S_WR) begin
         ram_we  = 4'b1111;
         ram_din = wdata_q;
      end else if (state_q == S_MERGE) begin
         ram_we  = 4'b1111;
         ram_din = merged;
      end

      ram_addr  = addr_q;
      busy      = (state_q != S_IDLE);
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
//
// Bench for dm_arbiter. A word-array RAM with 1-cycle read latency sits on the
// RAM side. Each access pushes its expected response into a per-port queue; a
// monitor on the falling edge pops and compares whenever an ack appears. A
// word-array reference memory, updated by plain lane arithmetic, supplies the
// expected load data and the final RAM contents.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

   localparam int ADDR_W = 11;
   localparam int WORDS  = 1 << ADDR_W;
   localparam int CLK_P  = 10;

   logic              clk;
   logic              rst_n;
   logic              c_req, c_wr, d_req, d_wr;
   logic [1:0]        c_size, d_size;
   logic [31:0]       c_addr, c_wdata, d_addr, d_wdata;
   logic              c_ack, d_ack;
   logic [31:0]       c_rdata, d_rdata;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_din;
   logic [31:0]       ram_dout;
   logic              busy;
   logic [2:0]        dbg_state;

   dm_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .c_req     (c_req),
      .c_wr      (c_wr),
      .c_size    (c_size),
      .c_addr    (c_addr),
      .c_wdata   (c_wdata),
      .c_ack     (c_ack),
      .c_rdata   (c_rdata),
      .d_req     (d_req),
      .d_wr      (d_wr),
      .d_size    (d_size),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #(CLK_P / 2) clk = ~clk;

   // ---------------------------------------------------------------------------
   // RAM: synchronous read, per-byte write enables
   // ---------------------------------------------------------------------------
   logic [31:0] mem [WORDS];

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
      end
      ram_dout <= mem[ram_addr];
   end

   // ---------------------------------------------------------------------------
   // Reference model and scoreboard state
   // ---------------------------------------------------------------------------
   logic [31:0] mdl     [WORDS];
   bit          written [WORDS];
   logic [32:0] exp_c_q [$];      // {is_load, expected rdata}
   logic [32:0] exp_d_q [$];
   bit          order_q [$];      // owner of each ack, in order (0 = C, 1 = D)

   int          errors = 0;
   int          checks = 0;

   time         ack_time;
   logic [3:0]  ack_we;
   logic [ADDR_W-1:0] ack_addr;
   logic [31:0] ack_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: pops an expected response for every ack
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst_n) begin
         chk("ack_exclusive", {31'h0, c_ack & d_ack}, 32'h0);
         chk("ram_we_legal", {31'h0, (ram_we == 4'h0) || (ram_we == 4'hF)}, 32'h1);
         if (ram_we == 4'h0) chk("ram_din_idle", ram_din, 32'h0);

         if (c_ack) begin
            order_q.push_back(1'b0);
            if (exp_c_q.size() == 0) begin
               chk("c_ack_unexpected", {31'h0, c_ack}, 32'h0);
            end else begin
               e = exp_c_q.pop_front();
               chk("c_rdata", c_rdata, e[32] ? e[31:0] : 32'h0);
            end
         end else begin
            chk("c_rdata_idle", c_rdata, 32'h0);
         end

         if (d_ack) begin
            order_q.push_back(1'b1);
            if (exp_d_q.size() == 0) begin
               chk("d_ack_unexpected", {31'h0, d_ack}, 32'h0);
            end else begin
               e = exp_d_q.pop_front();
               chk("d_rdata", d_rdata, e[32] ? e[31:0] : 32'h0);
            end
         end else begin
            chk("d_rdata_idle", d_rdata, 32'h0);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks. Callers are positioned 1 time unit after a rising edge.
   // ---------------------------------------------------------------------------
   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // One access on port p. exp_lat > 0 checks exact latency (uncontended);
   // exp_lat == 0 only bounds it by one foreign access plus its own.
   task automatic access(input bit p, input bit w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int exp_lat);
      int          lat;
      int          wi;
      int          lane;
      logic [32:0] e;
      bit          ack;

      wi = int'(a[ADDR_W+1:2]);
      if (!w) begin
         e = {1'b1, mdl[wi]};
      end else begin
         e = 33'h0;
         case (sz)
            2'b00: begin
               lane = int'(a[1:0]);
               mdl[wi][lane*8 +: 8] = wd[7:0];
            end
            2'b01: begin
               lane = int'(a[1]);
               mdl[wi][lane*16 +: 16] = wd[15:0];
            end
            default: mdl[wi] = wd;
         endcase
         written[wi] = 1'b1;
      end

      if (p) begin
         exp_d_q.push_back(e);
         d_wr = w; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
      end else begin
         exp_c_q.push_back(e);
         c_wr = w; c_size = sz; c_addr = a; c_wdata = wd; c_req = 1'b1;
      end

      lat = 0;
      ack = 1'b0;
      while (!ack && lat < 30) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         ack = p ? d_ack : c_ack;
      end
      if (!ack) begin
         chk(p ? "d_ack_timeout" : "c_ack_timeout", 32'h0, 32'h1);
      end else begin
         ack_time  = $time;
         ack_we    = ram_we;
         ack_addr  = ram_addr;
         ack_rdata = p ? d_rdata : c_rdata;
         if (exp_lat > 0) chk(p ? "d_latency" : "c_latency", lat, exp_lat);
         else             chk(p ? "d_wait_bound" : "c_wait_bound", {31'h0, lat <= 5}, 32'h1);
      end

      @(posedge clk);
      #1;
      if (p) d_req = 1'b0;
      else   c_req = 1'b0;
   endtask

   // Randomized traffic for one port inside its own 16-word region
   task automatic rand_port(input bit p, input logic [31:0] base, input int n);
      logic [31:0] a;
      for (int w = 0; w < 16; w++) begin
         access(p, 1'b1, 2'b10, base + 32'(w * 4), $urandom, 0);
      end
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) sync();
         a = ($urandom & 32'hFFFF_E000) | base
           | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
         access(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, 0);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #(CLK_P * 20000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      time t_prev;
      rst_n = 1'b0;
      c_req = 1'b0; c_wr = 1'b0; c_size = 2'b00; c_addr = 32'h0; c_wdata = 32'h0;
      d_req = 1'b0; d_wr = 1'b0; d_size = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",     {31'h0, busy},   32'h0);
      chk("rst_c_ack",    {31'h0, c_ack},  32'h0);
      chk("rst_d_ack",    {31'h0, d_ack},  32'h0);
      chk("rst_ram_we",   {28'h0, ram_we}, 32'h0);
      chk("rst_ram_din",  ram_din,         32'h0);
      chk("rst_ram_addr", {21'h0, ram_addr}, 32'h0);
      chk("rst_c_rdata",  c_rdata,         32'h0);
      rst_n = 1'b1;
      sync();

      // Word store then load on C
      access(1'b0, 1'b1, 2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 1);
      chk("wstore_we",   {28'h0, ack_we},   32'hF);
      chk("wstore_addr", {21'h0, ack_addr}, 32'h40);
      access(1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 2);
      chk("load_rdata", ack_rdata, 32'hDEAD_BEEF);

      // Sub-word merges
      access(1'b0, 1'b1, 2'b10, 32'h0000_0200, 32'h1122_3344, 1);
      access(1'b0, 1'b1, 2'b00, 32'h0000_0202, 32'h0000_00AA, 2);
      chk("merge_byte2", mem[11'h80], 32'h11AA_3344);
      access(1'b0, 1'b1, 2'b01, 32'h0000_0202, 32'h0000_BEEF, 2);
      chk("merge_half_hi", mem[11'h80], 32'hBEEF_3344);
      access(1'b0, 1'b1, 2'b00, 32'h0000_0203, 32'hFFFF_FF55, 2);
      chk("merge_byte3", mem[11'h80], 32'h55EF_3344);
      access(1'b0, 1'b1, 2'b01, 32'h0000_0201, 32'hFFFF_1234, 2);
      chk("merge_half_lo", mem[11'h80], 32'h55EF_1234);
      access(1'b0, 1'b1, 2'b00, 32'h0000_0200, 32'h0000_0099, 2);
      chk("merge_byte0", mem[11'h80], 32'h55EF_1299);
      access(1'b1, 1'b0, 2'b11, 32'hFFFF_E200, 32'h0, 2);
      chk("d_load_upper_ignored", ack_rdata, 32'h55EF_1299);

      // Back-to-back word stores on D
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         access(1'b1, 1'b1, 2'b10, 32'h0000_0300 + 32'(i * 4), 32'hA000_0000 + 32'(i), 1);
         if (i > 0) chk("b2b_interval", 32'(ack_time - t_prev), 32'(2 * CLK_P));
         t_prev = ack_time;
      end
      for (int i = 0; i < 4; i++) begin
         chk("b2b_word", mem[11'hC0 + 11'(i)], 32'hA000_0000 + 32'(i));
      end

      // Reset during the MERGE cycle of a byte store
      access(1'b0, 1'b1, 2'b10, 32'h0000_0204, 32'h0BAD_F00D, 1);
      c_wr = 1'b1; c_size = 2'b00; c_addr = 32'h0000_0204; c_wdata = 32'h0000_0055;
      c_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("mid_state_merge", {29'h0, dbg_state}, 32'h4);
      chk("mid_we_on",       {28'h0, ram_we},    32'hF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_we_off",   {28'h0, ram_we},     32'h0);
      chk("mid_c_ack",    {31'h0, c_ack},      32'h0);
      chk("mid_busy",     {31'h0, busy},       32'h0);
      chk("mid_ram_din",  ram_din,             32'h0);
      chk("mid_ram_addr", {21'h0, ram_addr},   32'h0);
      c_req = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      sync();
      chk("mid_word_kept", mem[11'h81], 32'h0BAD_F00D);
      access(1'b0, 1'b0, 2'b10, 32'h0000_0204, 32'h0, 2);
      chk("post_reset_load", ack_rdata, 32'h0BAD_F00D);

      // Contention from reset: grants alternate starting with C
      rst_n = 1'b0;
      sync();
      rst_n = 1'b1;
      sync();
      order_q.delete();
      fork
         for (int i = 0; i < 4; i++) access(1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0, 0);
         for (int i = 0; i < 4; i++) access(1'b1, 1'b0, 2'b10, 32'h0000_0300, 32'h0, 0);
      join
      chk("contend_count", order_q.size(), 32'd8);
      for (int i = 0; i < order_q.size(); i++) begin
         chk("contend_order", {31'h0, order_q[i]}, 32'(i % 2));
      end

      // Randomized traffic on disjoint regions
      fork
         rand_port(1'b0, 32'h0000_0400, 40);
         rand_port(1'b1, 32'h0000_0800, 40);
      join

      repeat (4) sync();
      chk("c_queue_empty", exp_c_q.size(), 32'h0);
      chk("d_queue_empty", exp_d_q.size(), 32'h0);
      for (int w = 0; w < WORDS; w++) begin
         if (written[w]) chk("ram_final", mem[w], mdl[w]);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
